// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch/issue unit with a loadable program memory,
//            valid/ready issue handshake, jumps, branches and halt.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int         AW      = 6,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          instr_ready,
  input  logic          zero,
  output logic [31:0]   Instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   issue_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_BRWAIT = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [5:0]    c_op_j   = 6'b000010;
  localparam logic [5:0]    c_op_beq = 6'b000100;
  localparam int            c_depth  = 1 << AW;
  localparam logic [AW-1:0] c_pc_one = AW'(1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [31:0]   r_mem [c_depth];
  logic [31:0]   r_instr;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_cnt;
  logic          w_stopped;
  logic          w_accept;
  logic [5:0]    w_opcode;
  logic [AW-1:0] w_offset;

  assign w_opcode  = r_instr[31:26];
  assign w_offset  = r_instr[AW-1:0];
  assign w_stopped = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_accept  = (r_state == S_ISSUE) && instr_ready;

  // Memory is deliberately left out of reset so programs survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && w_stopped) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (w_opcode == HALT_OP)       w_next = S_HALT;
          else if (w_opcode == c_op_beq) w_next = S_BRWAIT;
          else                           w_next = S_FETCH;
        end
      end
      S_BRWAIT:       w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc  <= '0;
            r_cnt <= '0;
          end
        end
        S_FETCH: r_instr <= r_mem[r_pc];
        S_ISSUE: begin
          if (w_accept) begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            // Halt and branch keep pc; branch target is resolved in BRWAIT.
            if (w_opcode == HALT_OP)       r_pc <= r_pc;
            else if (w_opcode == c_op_j)   r_pc <= w_offset;
            else if (w_opcode == c_op_beq) r_pc <= r_pc;
            else                           r_pc <= r_pc + c_pc_one;
          end
        end
        S_BRWAIT: r_pc <= r_pc + c_pc_one + (zero ? w_offset : '0);
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_valid = (r_state == S_ISSUE);
    busy        = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_BRWAIT);
    halted      = (r_state == S_HALT);
  end

  assign Instruction = r_instr;
  assign pc          = r_pc;
  assign issue_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch: vector table, directed
//            multi-cycle sequences and a randomized run against a model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;
  localparam int          AW      = 6;
  localparam int          DEPTH   = 64;
  localparam logic [5:0]  HALT_OP = 6'b111111;
  localparam logic [31:0] ADD_W   = 32'h00430820;
  localparam logic [31:0] SUB_W   = 32'h00A62022;
  localparam logic [31:0] HALT_W  = 32'hFC000000;
  localparam logic [31:0] J63_W   = 32'h0800003F;

  logic          clk = 1'b0;
  logic          rst_n, start, prog_we, instr_ready, zero;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   Instruction;
  logic          instr_valid, busy, halted;
  logic [AW-1:0] pc;
  logic [15:0]   issue_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic [31:0] word;
    logic        z;
    int          exp_pc;
    int          exp_gap;
    logic        exp_halt;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  instr_fetch #(.AW(AW), .HALT_OP(HALT_OP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .instr_ready(instr_ready),
    .zero(zero), .Instruction(Instruction), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .halted(halted), .issue_cnt(issue_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  // Accept the presented word, then count cycles until the next issue or halt.
  task automatic accept(output int gap);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    gap = 1;
    while (!instr_valid && !halted && gap < 20) begin
      @(negedge clk);
      gap++;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    int          r = $urandom_range(0, 9);
    logic [5:0]  op = w[31:26];
    if (r == 0)      op = HALT_OP;
    else if (r < 3)  op = 6'b000010;
    else if (r < 5)  op = 6'b000100;
    else if (op == HALT_OP || op == 6'b000010 || op == 6'b000100) op = 6'b000000;
    w[31:26] = op;
    return w;
  endfunction

  logic          m_active, m_halted, m_br, exp_v;
  logic          p_we, p_start, p_zero, p_acc;
  logic [AW-1:0] m_pc, m_off, p_addr;
  logic [31:0]   p_data, w;
  logic [15:0]   m_cnt;
  int            m_wait, gap;
  logic [31:0]   prog3 [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; instr_ready = 1'b0; zero = 1'b0;

    vecs[0] = '{ADD_W,        1'b0, 1,  2, 1'b0};
    vecs[1] = '{32'h08000005, 1'b0, 5,  2, 1'b0};
    vecs[2] = '{32'h10000003, 1'b1, 4,  3, 1'b0};
    vecs[3] = '{32'h10000003, 1'b0, 1,  3, 1'b0};
    vecs[4] = '{32'h1000003F, 1'b1, 0,  3, 1'b0};
    vecs[5] = '{J63_W,        1'b0, 63, 2, 1'b0};
    vecs[6] = '{HALT_W,       1'b0, 0,  1, 1'b1};
    vecs[7] = '{32'h0BFFFFC7, 1'b1, 7,  2, 1'b0};

    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_halt",  32'(halted),      32'd0);
    check("rst_pc",    32'(pc),          32'd0);
    check("rst_instr", Instruction,      32'd0);
    check("rst_cnt",   32'(issue_cnt),   32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_nofetch", 32'(busy), 32'd0);

    for (int i = 0; i < DEPTH; i++) load(i, 32'h00001000 + 32'(i));

    for (int i = 0; i < 8; i++) begin
      do_reset();
      load(0, vecs[i].word);
      zero = vecs[i].z;
      pulse_start();
      wait_valid($sformatf("vec%0d", i));
      accept(gap);
      check($sformatf("vec%0d_gap", i),  32'(gap),       32'(vecs[i].exp_gap));
      check($sformatf("vec%0d_halt", i), 32'(halted),    32'(vecs[i].exp_halt));
      check($sformatf("vec%0d_pc", i),   32'(pc),        32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_cnt", i),  32'(issue_cnt), 32'd1);
      if (!vecs[i].exp_halt)
        check($sformatf("vec%0d_instr", i), Instruction, mem_m[vecs[i].exp_pc]);
    end
    zero = 1'b0;

    // Three-instruction program; the word at 0 is written in the start cycle.
    prog3[0] = ADD_W; prog3[1] = SUB_W; prog3[2] = HALT_W;
    do_reset();
    load(0, 32'hDEADBEEF);
    load(1, SUB_W);
    load(2, HALT_W);
    prog_we = 1'b1; prog_addr = '0; prog_data = ADD_W; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0; mem_m[0] = ADD_W;
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("prog%0d", k));
      check($sformatf("prog%0d_instr", k), Instruction, prog3[k]);
      check($sformatf("prog%0d_pc", k),    32'(pc),     32'(k));
      accept(gap);
    end
    check("prog_halted", 32'(halted),      32'd1);
    check("prog_cnt",    32'(issue_cnt),   32'd3);
    check("prog_pc",     32'(pc),          32'd2);
    check("prog_valid",  32'(instr_valid), 32'd0);
    check("prog_busy",   32'(busy),        32'd0);

    // Stall in ISSUE for five cycles.
    do_reset();
    pulse_start();
    wait_valid("stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_instr", Instruction,      ADD_W);
      check("stall_pc",    32'(pc),          32'd0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_cnt",   32'(issue_cnt),   32'd0);
    end
    accept(gap);
    check("stall_acc_cnt", 32'(issue_cnt), 32'd1);
    check("stall_gap",     32'(gap),       32'd2);
    check("stall_next",    Instruction,    SUB_W);

    // Jump to the last word and wrap back to 0.
    do_reset();
    load(0, J63_W);
    load(63, ADD_W);
    pulse_start();
    wait_valid("wrap0");
    check("wrap_j_instr", Instruction, J63_W);
    accept(gap);
    check("wrap_pc63",    32'(pc),     32'd63);
    check("wrap_add",     Instruction, ADD_W);
    accept(gap);
    check("wrap_pc0",     32'(pc),     32'd0);
    check("wrap_j_again", Instruction, J63_W);
    check("wrap_cnt",     32'(issue_cnt), 32'd2);

    // Asynchronous reset between edges while in ISSUE.
    do_reset();
    load(0, ADD_W);
    load(1, SUB_W);
    pulse_start();
    wait_valid("arst");
    accept(gap);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_busy",  32'(busy),        32'd0);
    check("arst_halt",  32'(halted),      32'd0);
    check("arst_pc",    32'(pc),          32'd0);
    check("arst_instr", Instruction,      32'd0);
    check("arst_cnt",   32'(issue_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_nofetch", 32'(busy), 32'd0);

    // Writes while busy must be dropped.
    load(1, HALT_W);
    pulse_start();
    prog_we = 1'b1; prog_addr = '0; prog_data = SUB_W;
    wait_valid("bw0");
    accept(gap);
    wait_valid("bw1");
    accept(gap);
    prog_we = 1'b0;
    check("bw_halted", 32'(halted), 32'd1);
    pulse_start();
    wait_valid("bw_rd");
    check("bw_mem0", Instruction, mem_m[0]);

    // Randomized run against a transaction-level model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(i, rand_word());
    m_active = 1'b0; m_halted = 1'b0; m_br = 1'b0; m_pc = '0; m_off = '0;
    m_cnt = '0; m_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_v = m_active && (m_wait == 0);
      check("rnd_valid", 32'(instr_valid), 32'(exp_v));
      check("rnd_busy",  32'(busy),        32'(m_active));
      check("rnd_halt",  32'(halted),      32'(m_halted));
      check("rnd_cnt",   32'(issue_cnt),   32'(m_cnt));
      if (exp_v) begin
        check("rnd_instr", Instruction, mem_m[m_pc]);
        check("rnd_pc",    32'(pc),     32'(m_pc));
      end else if (!m_active) begin
        check("rnd_stop_pc", 32'(pc), 32'(m_pc));
      end
      instr_ready = ($urandom_range(0, 2) != 0);
      zero        = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 7) == 0);
      prog_we     = ($urandom_range(0, 3) == 0);
      prog_addr   = AW'($urandom_range(0, DEPTH - 1));
      prog_data   = rand_word();
      p_we = prog_we; p_addr = prog_addr; p_data = prog_data;
      p_start = start; p_zero = zero; p_acc = exp_v && instr_ready;
      @(negedge clk);
      if (!m_active) begin
        if (p_we) mem_m[p_addr] = p_data;
        if (p_start) begin
          m_active = 1'b1; m_halted = 1'b0; m_pc = '0; m_cnt = '0;
          m_wait = 1; m_br = 1'b0;
        end
      end else if (p_acc) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        w = mem_m[m_pc];
        if (w[31:26] == HALT_OP) begin
          m_active = 1'b0; m_halted = 1'b1;
        end else if (w[31:26] == 6'b000010) begin
          m_pc = w[AW-1:0]; m_wait = 1;
        end else if (w[31:26] == 6'b000100) begin
          m_off = w[AW-1:0]; m_br = 1'b1; m_wait = 2;
        end else begin
          m_pc = AW'(m_pc + 1); m_wait = 1;
        end
      end else if (m_wait > 0) begin
        if (m_br) begin
          m_pc = AW'(m_pc + 1 + (p_zero ? m_off : '0));
          m_br = 1'b0;
        end
        m_wait--;
      end
    end
    instr_ready = 1'b0; start = 1'b0; prog_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 6: instruction-memory address width; depth = 2**AW words of 32 bits.
REQ-002 Parameter HALT_OP, default 6'b111111: opcode that stops issue.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins execution at PC 0 from IDLE or HALT.
REQ-006 prog_we  input  1  program-load write enable.
REQ-007 prog_addr  input  AW  program-load word address.
REQ-008 prog_data  input  32  program-load word.
REQ-009 instr_ready  input  1  CPU accepts the presented Instruction this cycle.
REQ-010 zero  input  1  CPU ALU zero flag, sampled for branch resolution.
REQ-011 Instruction  output  32  registered instruction presented to the CPU.
REQ-012 instr_valid  output  1  Instruction is valid and awaiting acceptance.
REQ-013 pc  output  AW  current word address.
REQ-014 busy  output  1  high in FETCH, ISSUE, BRWAIT.
REQ-015 halted  output  1  high in HALT.
REQ-016 issue_cnt  output  16  count of accepted instructions.

Function
REQ-017 States: IDLE, FETCH, ISSUE, BRWAIT, HALT; single registered state variable.
REQ-018 prog_we writes mem[prog_addr] <= prog_data only in IDLE or HALT; writes while busy are ignored.
REQ-019 IDLE/HALT + start: pc <= 0, issue_cnt <= 0, next state FETCH; start in any other state is ignored.
REQ-020 FETCH: Instruction <= mem[pc]; next state ISSUE (one cycle in FETCH).
REQ-021 ISSUE: instr_valid = 1; Instruction and pc held stable until instr_valid && instr_ready.
REQ-022 Acceptance (ISSUE && instr_ready) increments issue_cnt, saturating at 16'hFFFF.
REQ-023 Accepted opcode [31:26] == HALT_OP: next state HALT, pc unchanged.
REQ-024 Accepted opcode 6'b000010 (J): pc <= Instruction[AW-1:0]; next state FETCH.
REQ-025 Accepted opcode 6'b000100 (BEQ): next state BRWAIT, pc unchanged.
REQ-026 BRWAIT (exactly one cycle): zero = 1 -> pc <= pc + 1 + Instruction[AW-1:0]; zero = 0 -> pc <= pc + 1; next state FETCH.
REQ-027 Any other accepted opcode: pc <= pc + 1; next state FETCH.
REQ-028 All pc arithmetic is modulo 2**AW (pc = 2**AW-1 plus 1 wraps to 0); offsets are unsigned AW-bit.
REQ-029 Latency: an ordinary instruction accepted in cycle N is followed by instr_valid for the next word in cycle N+2; BEQ in cycle N+3.
REQ-030 instr_valid = 0 in IDLE, FETCH, BRWAIT, HALT; valid never deasserts in ISSUE without acceptance.
REQ-031 Simultaneous prog_we and start in IDLE: write completes first; the fetch of PC 0 sees the new word if prog_addr = 0.

Reset
REQ-032 rst_n low forces immediately, regardless of clk: state IDLE, pc 0, Instruction 0, instr_valid 0, busy 0, halted 0, issue_cnt 0.
REQ-033 Memory contents are not reset; reset mid-operation abandons the pending instruction with no acceptance counted.
REQ-034 After rst_n rises, no fetch occurs until start.

Verification
REQ-035 Load mem[0..2] = ADD 32'h00430820, SUB 32'h00A62022, HALT 32'hFC000000; start; instr_ready = 1 -> ADD, SUB, HALT issued in order, halted = 1, issue_cnt = 3, pc = 2.
REQ-036 ISSUE with instr_ready held 0 for 5 cycles -> Instruction, pc, instr_valid stable; single acceptance on the cycle instr_ready rises; issue_cnt += 1.
REQ-037 mem[0] = BEQ offset 3 (32'h10000003), zero = 1 in BRWAIT -> next fetch pc = 4; repeat with zero = 0 -> pc = 1.
REQ-038 mem[0] = J 63 (32'h0800003F), mem[63] = ADD, mem[0] reached again after ADD -> pc wraps 63 -> 0; J re-issued.
REQ-039 Assert rst_n low during ISSUE between clock edges -> outputs reach REQ-032 values before the next edge; prog_we during busy leaves memory unchanged (read back after HALT).
